dcache_ctrl: RTL

- Direct-mapped, write-back, write-allocate data cache controller.
- Sits directly downstream of the core's MEM-stage data port (mem_ren/mem_wen/mem_addr/mem_dout/mem_din) and upstream of external word-wide memory.
- Hits complete in the same cycle. Misses raise core_stall while a single FSM writes back a dirty victim line and refills the line.

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_store.sv | 52 +++++
 rtl/dcache_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared configuration, FSM state encoding and address-field helpers for the
// direct-mapped write-back data cache (dcache_ctrl, dcache_store).
package dcache_pkg;
    localparam int LINE_WORDS = 4;
    localparam int LINE_NUM   = 64;
    localparam int ADDR_W     = 32;

    localparam int OFFSET_W = $clog2(LINE_WORDS);
    localparam int INDEX_W  = $clog2(LINE_NUM);
    localparam int TAG_W    = ADDR_W - 2 - OFFSET_W - INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2
    } state_t;

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W+1:2];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W+INDEX_W+1:OFFSET_W+2];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:ADDR_W-TAG_W];
    endfunction

    function automatic logic [ADDR_W-1:0] make_addr(input logic [TAG_W-1:0]    tag,
                                                    input logic [INDEX_W-1:0]  index,
                                                    input logic [OFFSET_W-1:0] offset);
        return {tag, index, offset, 2'b00};
    endfunction
endpackage

// File: rtl/dcache_store.sv
// Tag/valid/dirty and data arrays of the data cache: asynchronous read,
// synchronous write of one word or one tag per cycle at the selected line.
module dcache_store
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  index,
    input  logic [OFFSET_W-1:0] offset,
    output logic [TAG_W-1:0]    rd_tag,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [31:0]         rd_word,
    input  logic                word_we,
    input  logic [31:0]         wr_word,
    input  logic                tag_we,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic                dirty_set,
    input  logic                dirty_clr
);
    logic [TAG_W-1:0]    tag_ram  [LINE_NUM];
    logic [31:0]         data_ram [LINE_NUM][LINE_WORDS];
    logic [LINE_NUM-1:0] valid;
    logic [LINE_NUM-1:0] dirty;

    assign rd_tag   = tag_ram[index];
    assign rd_valid = valid[index];
    assign rd_dirty = dirty[index];
    assign rd_word  = data_ram[index][offset];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (tag_we)
                valid[index] <= 1'b1;
            if (dirty_set)
                dirty[index] <= 1'b1;
            else if (dirty_clr)
                dirty[index] <= 1'b0;
        end
    end

    // Tag and data contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (tag_we)
            tag_ram[index] <= wr_tag;
        if (word_we)
            data_ram[index][offset] <= wr_word;
    end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Optional hit/miss statistics counters are built when DCACHE_STAT_EN is defined.
//   state  | meaning
//   S_IDLE | serve hits in the same cycle; detect misses
//   S_WB   | write the dirty victim line back, one word per mem_ack
//   S_FILL | read the requested line from memory, one word per mem_ack
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              core_ren,
    input  logic              core_wen,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_din,
    output logic [31:0]       core_dout,
    output logic              core_stall,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_dout,
    input  logic [31:0]       mem_din,
    input  logic              mem_ack
`ifdef DCACHE_STAT_EN
    ,
    output logic [31:0]       stat_hit,
    output logic [31:0]       stat_miss
`endif
);
    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(LINE_WORDS - 1);

    state_t              state, state_nx;
    logic [OFFSET_W-1:0] cnt;
    logic [INDEX_W-1:0]  miss_index, index;
    logic [TAG_W-1:0]    miss_tag, rd_tag;
    logic [OFFSET_W-1:0] offset;
    logic                req, hit, miss, last_ack;
    logic                rd_valid, rd_dirty;
    logic [31:0]         rd_word, wr_word;
    logic                word_we, tag_we, dirty_set, dirty_clr;

    assign req      = core_ren | core_wen;
    // The miss line is latched so a withdrawn request still completes its fill.
    assign index    = (state == S_IDLE) ? addr_index(core_addr)  : miss_index;
    assign offset   = (state == S_IDLE) ? addr_offset(core_addr) : cnt;
    assign hit      = rd_valid && (rd_tag == addr_tag(core_addr));
    assign miss     = (state == S_IDLE) && req && !hit;
    assign last_ack = mem_ack && (cnt == LAST_WORD);

    dcache_store u_store (
        .clk      (clk),
        .rst      (rst),
        .index    (index),
        .offset   (offset),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_word  (rd_word),
        .word_we  (word_we),
        .wr_word  (wr_word),
        .tag_we   (tag_we),
        .wr_tag   (miss_tag),
        .dirty_set(dirty_set),
        .dirty_clr(dirty_clr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            miss_index <= '0;
            miss_tag   <= '0;
        end else begin
            if (state == S_IDLE)
                cnt <= '0;
            else if (mem_ack)
                cnt <= cnt + 1'b1;
            if (miss) begin
                miss_index <= addr_index(core_addr);
                miss_tag   <= addr_tag(core_addr);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (miss) state_nx = (rd_valid && rd_dirty) ? S_WB : S_FILL;
            S_WB:    if (last_ack) state_nx = S_FILL;
            S_FILL:  if (last_ack) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        core_dout  = '0;
        core_stall = 1'b0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_dout   = '0;
        word_we    = 1'b0;
        wr_word    = core_din;
        tag_we     = 1'b0;
        dirty_set  = 1'b0;
        dirty_clr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (core_ren && hit)
                    core_dout = rd_word;
                if (core_wen && hit) begin
                    word_we   = 1'b1;
                    dirty_set = 1'b1;
                end
                // A request held across reset must not report a stall.
                core_stall = miss && rst;
            end
            S_WB: begin
                core_stall = 1'b1;
                mem_cs     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = make_addr(rd_tag, miss_index, cnt);
                mem_dout   = rd_word;
                dirty_clr  = last_ack;
            end
            S_FILL: begin
                core_stall = 1'b1;
                mem_cs     = 1'b1;
                mem_addr   = make_addr(miss_tag, miss_index, cnt);
                word_we    = mem_ack;
                wr_word    = mem_din;
                tag_we     = last_ack;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_STAT_EN
    // The first IDLE cycle after a fill replays the stalled request; it is not a new hit.
    logic replay;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            replay    <= 1'b0;
            stat_hit  <= '0;
            stat_miss <= '0;
        end else begin
            replay <= (state == S_FILL) && last_ack;
            if ((state == S_IDLE) && req && hit && !replay && (stat_hit != '1))
                stat_hit <= stat_hit + 32'd1;
            if (miss && (stat_miss != '1))
                stat_miss <= stat_miss + 32'd1;
        end
    end
`endif
endmodule
